// File: rtl/bp_cce_mem_responder_pkg.sv
// Shared CCE-MEM message types and processor constants for the memory responder.
// The header fields are echoed unchanged in every response.
package bp_cce_mem_responder_pkg;

    localparam int paddr_width_gp     = 40;
    localparam int cce_block_width_gp = 512;
    localparam int lce_id_width_gp    = 4;
    localparam int lce_max_assoc_gp   = 8;
    localparam int block_bytes_gp     = cce_block_width_gp / 8;
    localparam int lg_block_bytes_gp  = $clog2(block_bytes_gp);
    localparam int way_id_width_gp    = $clog2(lce_max_assoc_gp);

    typedef enum logic [3:0] {
        e_cce_mem_rd    = 4'd0,
        e_cce_mem_wr    = 4'd1,
        e_cce_mem_uc_rd = 4'd2,
        e_cce_mem_uc_wr = 4'd3,
        e_cce_mem_wb    = 4'd4
    } bp_cce_mem_cmd_type_e;

    typedef enum logic [2:0] {
        e_mem_size_1  = 3'd0,
        e_mem_size_2  = 3'd1,
        e_mem_size_4  = 3'd2,
        e_mem_size_8  = 3'd3,
        e_mem_size_16 = 3'd4,
        e_mem_size_32 = 3'd5,
        e_mem_size_64 = 3'd6
    } bp_cce_mem_req_size_e;

    typedef enum logic [1:0] {
        e_ready = 2'd0,
        e_wait  = 2'd1,
        e_resp  = 2'd2
    } bp_cce_mem_responder_state_e;

    typedef struct packed {
        logic [2:0]                 state;
        logic [way_id_width_gp-1:0] way_id;
        logic [lce_id_width_gp-1:0] lce_id;
    } bp_cce_mem_payload_s;

    typedef struct packed {
        logic [cce_block_width_gp-1:0] data;
        bp_cce_mem_payload_s           payload;
        bp_cce_mem_req_size_e          size;
        logic [paddr_width_gp-1:0]     addr;
        bp_cce_mem_cmd_type_e          msg_type;
    } bp_cce_mem_msg_s;

    localparam int cce_mem_msg_width_gp = $bits(bp_cce_mem_msg_s);

    function automatic int unsigned size_bytes(input bp_cce_mem_req_size_e s);
        return 32'd1 << s;
    endfunction

endpackage

// File: rtl/bp_cce_mem_responder_storage.sv
// Block storage: synchronous per-byte-masked write, combinational read of the addressed block.
// Contents are intentionally never reset.
module bp_mem_storage_block #(
    parameter int els_p   = 256,
    parameter int width_p = 512,
    localparam int bytes_lp  = width_p / 8,
    localparam int lg_els_lp = $clog2(els_p)
) (
    input  logic                 clk_i,
    input  logic                 w_v_i,
    input  logic [lg_els_lp-1:0] addr_i,
    input  logic [bytes_lp-1:0]  w_mask_i,
    input  logic [width_p-1:0]   w_data_i,
    output logic [width_p-1:0]   r_data_o
);

    logic [width_p-1:0] mem_q [els_p];

    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            for (int b = 0; b < bytes_lp; b++) begin
                if (w_mask_i[b]) mem_q[addr_i][b*8 +: 8] <= w_data_i[b*8 +: 8];
            end
        end
    end

    assign r_data_o = mem_q[addr_i];

endmodule

// File: rtl/bp_cce_mem_responder.sv
// Memory endpoint for the CCE: one command at a time, response after mem_latency_p cycles.
// Read data and the echoed header are captured at acceptance and held until yumi.
module bp_cce_mem_responder
    import bp_cce_mem_responder_pkg::*;
#(
    parameter int mem_blocks_p  = 256,
    parameter int mem_latency_p = 4,
    localparam int cce_mem_msg_width_lp = cce_mem_msg_width_gp
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
    input  logic                            mem_cmd_v_i,
    output logic                            mem_cmd_ready_o,
    output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
    output logic                            mem_resp_v_o,
    input  logic                            mem_resp_yumi_i
);

    localparam int lg_blocks_lp = $clog2(mem_blocks_p);
    localparam int cnt_width_lp = (mem_latency_p > 1) ? $clog2(mem_latency_p) : 1;
    localparam logic [cnt_width_lp-1:0] cnt_load_lp = cnt_width_lp'(mem_latency_p - 1);

    if (mem_latency_p < 1) begin : g_bad_latency
        $error("mem_latency_p must be >= 1");
    end
    if ((mem_blocks_p < 2) || ((mem_blocks_p & (mem_blocks_p - 1)) != 0)) begin : g_bad_blocks
        $error("mem_blocks_p must be a power of two >= 2");
    end

    bp_cce_mem_responder_state_e state_q, state_d;
    logic [cnt_width_lp-1:0]     cnt_q, cnt_d;
    bp_cce_mem_msg_s             resp_q, resp_d;
    bp_cce_mem_msg_s             cmd;

    logic                          accept;
    logic [lg_block_bytes_gp-1:0]  offset;
    logic [lg_blocks_lp-1:0]       blk_idx;
    logic                          full_size;
    logic [block_bytes_gp-1:0]     size_mask;
    logic [cce_block_width_gp-1:0] size_bits;
    logic [cce_block_width_gp-1:0] blk_rdata, rd_data, w_data;
    logic [block_bytes_gp-1:0]     w_mask;
    logic                          w_v;

    assign cmd             = mem_cmd_i;
    assign mem_cmd_ready_o = (state_q == e_ready) & ~reset_i;
    assign mem_resp_v_o    = (state_q == e_resp);
    assign mem_resp_o      = resp_q;
    assign accept          = mem_cmd_v_i & mem_cmd_ready_o;

    // Upper address bits are dropped so addresses alias modulo capacity.
    assign offset    = cmd.addr[lg_block_bytes_gp-1:0];
    assign blk_idx   = cmd.addr[lg_block_bytes_gp +: lg_blocks_lp];
    assign full_size = (cmd.size >= 3'(lg_block_bytes_gp));

    always_comb begin
        size_mask = full_size ? '1
                  : (block_bytes_gp'(1) << size_bytes(cmd.size)) - block_bytes_gp'(1);
        size_bits = '0;
        for (int b = 0; b < block_bytes_gp; b++) size_bits[b*8 +: 8] = {8{size_mask[b]}};
    end

    // Shifts truncate sub-block accesses at the block end on both paths.
    always_comb begin
        w_v     = 1'b0;
        w_mask  = '0;
        w_data  = '0;
        rd_data = '0;
        case (cmd.msg_type)
            e_cce_mem_wr, e_cce_mem_wb: begin
                w_v    = accept;
                w_mask = '1;
                w_data = cmd.data;
            end
            e_cce_mem_uc_wr: begin
                w_v    = accept;
                w_mask = size_mask << offset;
                w_data = cmd.data << {offset, 3'b000};
            end
            e_cce_mem_rd:    rd_data = blk_rdata;
            e_cce_mem_uc_rd: rd_data = full_size ? blk_rdata
                                     : (blk_rdata >> {offset, 3'b000}) & size_bits;
            default: ;
        endcase
    end

    bp_mem_storage_block #(
        .els_p  (mem_blocks_p),
        .width_p(cce_block_width_gp)
    ) storage (
        .clk_i   (clk_i),
        .w_v_i   (w_v),
        .addr_i  (blk_idx),
        .w_mask_i(w_mask),
        .w_data_i(w_data),
        .r_data_o(blk_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        case (state_q)
            e_ready: if (accept) begin
                resp_d      = cmd;
                resp_d.data = rd_data;
                cnt_d       = cnt_load_lp;
                state_d     = (mem_latency_p == 1) ? e_resp : e_wait;
            end
            e_wait: begin
                cnt_d = cnt_q - cnt_width_lp'(1);
                if (cnt_q <= cnt_width_lp'(1)) state_d = e_resp;
            end
            e_resp:  if (mem_resp_yumi_i) state_d = e_ready;
            default: state_d = e_ready;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_ready;
            cnt_q   <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
        end
    end

    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        mem_resp_yumi_i |-> mem_resp_v_o)
        else $error("mem_resp_yumi_i asserted without mem_resp_v_o");

endmodule

// File: tb/tb_bp_cce_mem_responder.sv
// Directed bench for bp_cce_mem_responder with a byte-level reference memory and response scoreboard.
module tb_bp_cce_mem_responder;
    import bp_cce_mem_responder_pkg::*;

    localparam int W = cce_mem_msg_width_gp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [W-1:0] cmd, resp, cmd1, resp1;
    logic         cmd_v, cmd_ready, resp_v, yumi;
    logic         v1, ready1, rv1, y1;

    bp_cce_mem_responder #(.mem_blocks_p(256), .mem_latency_p(4)) dut (
        .clk_i(clk), .reset_i(reset),
        .mem_cmd_i(cmd), .mem_cmd_v_i(cmd_v), .mem_cmd_ready_o(cmd_ready),
        .mem_resp_o(resp), .mem_resp_v_o(resp_v), .mem_resp_yumi_i(yumi));

    bp_cce_mem_responder #(.mem_blocks_p(256), .mem_latency_p(1)) dut1 (
        .clk_i(clk), .reset_i(reset),
        .mem_cmd_i(cmd1), .mem_cmd_v_i(v1), .mem_cmd_ready_o(ready1),
        .mem_resp_o(resp1), .mem_resp_v_o(rv1), .mem_resp_yumi_i(y1));

    int nvec  = 0;
    int nfail = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bp_cce_mem_msg_s exp_q[$];
    logic [7:0]      model[int];

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bp_cce_mem_msg_s mk(input bp_cce_mem_cmd_type_e t, input logic [39:0] a,
                                           input bp_cce_mem_req_size_e s, input logic [511:0] d);
        bp_cce_mem_msg_s m;
        m          = '0;
        m.msg_type = t;
        m.addr     = a;
        m.size     = s;
        m.data     = d;
        m.payload  = '{state: 3'd2, way_id: 3'd3, lce_id: 4'd5};
        return m;
    endfunction

    // Reference: 256 blocks of 64 bytes, little-endian bytes within the data field.
    task automatic model_apply(input bp_cce_mem_msg_s c, output bp_cce_mem_msg_s r);
        int blk, off, n;
        blk    = int'(c.addr[13:6]);
        off    = int'(c.addr[5:0]);
        n      = 1 << int'(c.size);
        r      = c;
        r.data = '0;
        case (c.msg_type)
            e_cce_mem_wr, e_cce_mem_wb:
                for (int b = 0; b < 64; b++) model[blk*64 + b] = c.data[b*8 +: 8];
            e_cce_mem_uc_wr:
                for (int i = 0; i < n; i++) if (off + i < 64) model[blk*64 + off + i] = c.data[i*8 +: 8];
            e_cce_mem_rd:
                for (int b = 0; b < 64; b++) r.data[b*8 +: 8] = model[blk*64 + b];
            e_cce_mem_uc_rd:
                if (n >= 64) begin
                    for (int b = 0; b < 64; b++) r.data[b*8 +: 8] = model[blk*64 + b];
                end else begin
                    for (int i = 0; i < n; i++) if (off + i < 64) r.data[i*8 +: 8] = model[blk*64 + off + i];
                end
            default: ;
        endcase
    endtask

    task automatic send(input bp_cce_mem_msg_s c, output int acc);
        bp_cce_mem_msg_s r;
        int w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
        check("cmd_ready_before_send", W'(cmd_ready), W'(1'b1));
        acc   = cyc;
        cmd   = c;
        cmd_v = 1'b1;
        model_apply(c, r);
        exp_q.push_back(r);
        @(posedge clk); #1;
        cmd_v = 1'b0;
    endtask

    task automatic get(input string tag, input int acc, input int hold, output bp_cce_mem_msg_s got);
        bp_cce_mem_msg_s e;
        int w = 0;
        @(negedge clk);
        while (!resp_v && w < 50) begin @(negedge clk); w++; end
        check({tag, "_resp_v"}, W'(resp_v), W'(1'b1));
        check({tag, "_latency"}, W'(cyc - acc), W'(4));
        e   = exp_q.pop_front();
        got = resp;
        check(tag, resp, e);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_stable"}, resp, e);
            check({tag, "_hold_not_ready"}, W'(cmd_ready), W'(1'b0));
        end
        yumi = 1'b1;
        @(posedge clk); #1;
        yumi = 1'b0;
        @(negedge clk);
        check({tag, "_ready_after_yumi"}, W'(cmd_ready), W'(1'b1));
        check({tag, "_v_after_yumi"}, W'(resp_v), W'(1'b0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bp_cce_mem_msg_s got, m1;
        logic [511:0] pat, pat2, pat3, exp_blk;
        int acc, saw_v;

        reset = 1'b1; cmd = '0; cmd_v = 1'b0; yumi = 1'b0;
        cmd1 = '0; v1 = 1'b0; y1 = 1'b0;
        for (int i = 0; i < 64; i++) begin
            pat[i*8 +: 8]  = 8'(i);
            pat2[i*8 +: 8] = 8'(i) ^ 8'h5A;
            pat3[i*8 +: 8] = 8'(255 - i);
        end

        repeat (3) @(negedge clk);
        check("reset_ready", W'(cmd_ready), W'(1'b0));
        check("reset_resp_v", W'(resp_v), W'(1'b0));
        check("reset_resp", resp, '0);
        check("reset_ready_lat1", W'(ready1), W'(1'b0));
        reset = 1'b0;

        send(mk(e_cce_mem_uc_wr, 40'h80, e_mem_size_8, 512'hDEADBEEF_CAFEF00D), acc);
        get("uc_wr_8B", acc, 0, got);
        send(mk(e_cce_mem_uc_rd, 40'h80, e_mem_size_8, '0), acc);
        get("uc_rd_8B", acc, 0, got);
        check("uc_rd_8B_data", W'(got.data), W'(512'hDEADBEEF_CAFEF00D));

        send(mk(e_cce_mem_wr, 40'h1000, e_mem_size_64, pat), acc);
        get("blk_wr", acc, 0, got);
        send(mk(e_cce_mem_rd, 40'h1010, e_mem_size_64, '0), acc);
        get("blk_rd_aligned", acc, 0, got);
        check("blk_rd_aligned_data", W'(got.data), W'(pat));

        send(mk(e_cce_mem_uc_wr, 40'h1005, e_mem_size_1, 512'hAA), acc);
        get("uc_wr_1B", acc, 0, got);
        send(mk(e_cce_mem_rd, 40'h1000, e_mem_size_64, '0), acc);
        get("blk_rd_after_byte", acc, 0, got);
        exp_blk = pat;
        exp_blk[5*8 +: 8] = 8'hAA;
        check("blk_rd_after_byte_data", W'(got.data), W'(exp_blk));

        send(mk(e_cce_mem_uc_rd, 40'h103C, e_mem_size_8, '0), acc);
        get("uc_rd_trunc", acc, 0, got);
        check("uc_rd_trunc_data", W'(got.data), W'(512'h3F3E3D3C));

        send(mk(e_cce_mem_uc_rd, 40'h1000, e_mem_size_64, '0), acc);
        get("hold_resp", acc, 10, got);

        send(mk(e_cce_mem_wr, 40'h2000, e_mem_size_64, pat2), acc);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        void'(exp_q.pop_front());
        saw_v = 0;
        repeat (8) begin
            @(negedge clk);
            if (resp_v) saw_v = 1;
        end
        check("reset_wait_no_resp_v", W'(saw_v), W'(0));
        check("reset_wait_ready", W'(cmd_ready), W'(1'b1));
        send(mk(e_cce_mem_rd, 40'h2000, e_mem_size_64, '0), acc);
        get("rd_after_reset", acc, 0, got);
        check("rd_after_reset_data", W'(got.data), W'(pat2));

        send(mk(e_cce_mem_wr, 40'h0, e_mem_size_64, pat3), acc);
        get("alias_wr", acc, 0, got);
        send(mk(e_cce_mem_rd, 40'h4000, e_mem_size_64, '0), acc);
        get("alias_rd", acc, 0, got);
        check("alias_rd_data", W'(got.data), W'(pat3));

        // Latency-1 instance: response is visible the cycle right after acceptance.
        @(negedge clk);
        check("lat1_ready", W'(ready1), W'(1'b1));
        m1 = mk(e_cce_mem_uc_wr, 40'h40, e_mem_size_4, 512'h12345678);
        cmd1 = m1; v1 = 1'b1;
        @(posedge clk); #1; v1 = 1'b0;
        @(negedge clk);
        check("lat1_wr_resp_v", W'(rv1), W'(1'b1));
        m1.data = '0;
        check("lat1_wr_resp", resp1, m1);
        y1 = 1'b1;
        @(posedge clk); #1; y1 = 1'b0;
        @(negedge clk);
        check("lat1_ready_after_yumi", W'(ready1), W'(1'b1));
        m1 = mk(e_cce_mem_uc_rd, 40'h41, e_mem_size_2, '0);
        cmd1 = m1; v1 = 1'b1;
        @(posedge clk); #1; v1 = 1'b0;
        @(negedge clk);
        check("lat1_rd_resp_v", W'(rv1), W'(1'b1));
        m1.data = 512'h3456;
        check("lat1_rd_offset", resp1, m1);
        y1 = 1'b1;
        @(posedge clk); #1; y1 = 1'b0;
        @(negedge clk);
        check("lat1_v_after_yumi", W'(rv1), W'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/bp_cce_mem_responder.md
Name: bp_cce_mem_responder

Overview:
- Memory-side endpoint of the CCE-MEM interface: accepts bp_cce_mem_msg_s commands from a CCE and returns one bp_cce_mem_msg_s response per command after a programmable latency.
- Backed by a block-organized storage array.
- Used as the simulation/FPGA memory behind the CCE. It also serves as the unit-test counterpart for the CCE's cached and uncached message paths.

Parameters:
- bp_params_p, "inv": processor parameter bundle; supplies paddr_width_p, cce_block_width_p, lce_id_width_p, lce_max_assoc_p.
- mem_blocks_p, 256: number of cce_block_width_p-bit blocks in storage; must be a power of two.
- mem_latency_p, 4: cycles from command acceptance to mem_resp_v_o; must be >= 1 (elaboration assertion).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- mem_cmd_i  in  cce_mem_msg_width_lp  command message: header plus block data
- mem_cmd_v_i  in  1  command valid
- mem_cmd_ready_o  out  1  ready; ready&valid handshake
- mem_resp_o  out  cce_mem_msg_width_lp  response message
- mem_resp_v_o  out  1  response valid
- mem_resp_yumi_i  in  1  consumer takes the response; valid-then-yumi handshake

Behaviour:
- The interface is one clock (clk_i) with synchronous, active-high reset (reset_i).
- FSM states: e_ready, e_wait, e_resp.
- Reset values: state=e_ready, latency counter=0, mem_cmd_ready_o=0 during reset, mem_resp_v_o=0, mem_resp_o=0.
- Storage contents are not cleared by reset; they are preserved across reset and undefined at power-up.

- e_ready:
  - mem_cmd_ready_o=1.
  - On mem_cmd_v_i&mem_cmd_ready_o, the command is accepted at that edge:
    - header and data are latched;
    - a write updates storage at this edge;
    - read data is captured into the response register at this edge;
    - counter is loaded with mem_latency_p-1;
    - go to e_wait, or to e_resp directly if mem_latency_p==1.
- e_wait:
  - mem_cmd_ready_o=0.
  - Counter decrements each cycle; at 0, go to e_resp.
- e_resp:
  - mem_resp_v_o=1; mem_resp_o is held stable until mem_resp_yumi_i.
  - On yumi, go to e_ready. The next command cannot be accepted in the same cycle as yumi.
- Latency: a command accepted at edge T has mem_resp_v_o high starting cycle T+mem_latency_p.
- Exactly one outstanding command at a time.

- Addressing:
  - block index = addr[lg_block_bytes +: lg(mem_blocks_p)]; upper address bits are ignored, so addresses alias modulo capacity.
  - byte offset = addr[lg_block_bytes-1:0].
- Command handling by msg_type:
  - e_cce_mem_rd, e_cce_mem_uc_rd with size = full block: response data = entire block, aligned to block boundary (offset ignored).
  - e_cce_mem_uc_rd with size < block: response data LSBs = size bytes starting at offset; upper bits are zero.
  - e_cce_mem_wr, e_cce_mem_wb: the full block is written at the block index.
  - e_cce_mem_uc_wr: size bytes taken from the data LSBs are written at offset; other bytes are untouched.
  - Write responses carry data=0.
  - An access that crosses the block boundary (offset+size > block bytes) is truncated at the block end.
- Response header = command header echoed unchanged (msg_type, addr, size, payload incl. lce_id/way/state).
- Storage write and response read on the same edge never conflict, because a single command is either a read or a write.
- A write followed by a read to the same address returns the new data.
- Reset mid-operation (e_wait or e_resp):
  - the pending response is discarded;
  - a write already applied at acceptance stays applied;
  - the FSM returns to e_ready.
- mem_resp_yumi_i asserted while mem_resp_v_o=0 is ignored; a simulation assertion flags it.

Decomposition:
- Shared package (bp_me_pkg / bp_cce_pkg, existing):
  - bp_cce_mem_cmd_type_e
  - bp_cce_mem_req_size_e
  - bp_cce_mem_msg_s
  - the width macros for these types
- New shared enum bp_cce_mem_responder_state_e {e_ready, e_wait, e_resp} in bp_me_pkg.
- One natural sub-module: bp_mem_storage_block.
  - Single-port synchronous-write array of mem_blocks_p blocks with per-byte write mask.
  - Combinational read of the addressed block, registered by the parent.
- Size-to-byte-mask and byte extraction stay in the parent as combinational logic.

Test Plan:
- Reset, then uc_wr size 8B, addr 0x80, data 0xDEADBEEF_CAFEF00D; yumi immediately -> resp_v at T+4, msg_type uc_wr, addr 0x80, data 0. Then uc_rd 8B at 0x80 -> data LSBs 0xDEADBEEF_CAFEF00D, upper bits 0.
- Block wr of pattern {byte i = i} to 0x1000, then rd at 0x1010 -> full block returned, aligned; byte i = i.
- uc_wr 1B 0xAA at 0x1005, then block rd at 0x1000 -> only byte 5 = 0xAA; all other bytes unchanged.
- Hold mem_resp_yumi_i low for 10 cycles after resp_v -> mem_resp_o stable, mem_cmd_ready_o=0 throughout; yumi -> ready=1 the next cycle.
- Assert reset in e_wait after a block wr -> resp_v never asserted; a subsequent rd returns the written data.
- Aliasing: with mem_blocks_p=256 and 64B blocks, wr at 0x0 then rd at 0x4000 -> same data. With mem_latency_p=1, resp_v occurs the cycle after acceptance.
